seven_seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display. It decodes 4-bit nibbles in BCD or hex mode, with per-digit decimal points, per-digit enables and leading-zero suppression. A load strobe captures new display data into a double buffer, which is committed only at frame boundaries so the display never tears. It sits between datapath counters and board display pins, superseding the single-digit combinational decoder.

---
 rtl/seven_seg_pkg.sv | 54 +++++
 rtl/seven_seg_glyph.sv | 12 +
 rtl/seven_seg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared glyph table and nibble decoder for the seven-segment scan driver.
// Patterns are lit-high in {g,f,e,d,c,b,a} order; polarity is applied at the pins.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        PHASE_BLANK,
        PHASE_SHOW
    } scan_phase_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b1111100;
    localparam seg_t SEG_C     = 7'b0111001;
    localparam seg_t SEG_D     = 7'b1011110;
    localparam seg_t SEG_E     = 7'b1111001;
    localparam seg_t SEG_F     = 7'b1110001;
    localparam seg_t SEG_BLANK = 7'b0000000;

    // Values 10-15 only have a glyph in hex mode; in BCD mode they go dark.
    function automatic seg_t glyph(input logic [3:0] nibble, input logic hexMode);
        seg_t pattern;
        case (nibble)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = hexMode ? SEG_A : SEG_BLANK;
            4'hB:    pattern = hexMode ? SEG_B : SEG_BLANK;
            4'hC:    pattern = hexMode ? SEG_C : SEG_BLANK;
            4'hD:    pattern = hexMode ? SEG_D : SEG_BLANK;
            4'hE:    pattern = hexMode ? SEG_E : SEG_BLANK;
            default: pattern = hexMode ? SEG_F : SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational nibble-to-segment decoder, lit-high output.
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_hexMode,
    output seg_t       o_segments
);

    assign o_segments = glyph(i_nibble, i_hexMode);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a frame-synchronous
// double buffer, leading-zero suppression and per-slot anode blanking.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    hex_mode,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]      BLANK_END  = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam seg_t                  SEG_POL    = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL     = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        r_slotCnt;
    logic [IDX_W-1:0]        r_digitIdx;
    logic [4*NUM_DIGITS-1:0] r_shadowDigits;
    logic [NUM_DIGITS-1:0]   r_shadowDp;
    logic [NUM_DIGITS-1:0]   r_shadowEn;
    logic [4*NUM_DIGITS-1:0] r_activeDigits;
    logic [NUM_DIGITS-1:0]   r_activeDp;
    logic [NUM_DIGITS-1:0]   r_activeEn;
    logic                    r_pending;
    logic                    r_wrapDly;
    logic                    r_frameDone;
    seg_t                    r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_slotWrap;
    logic                    w_commit;
    logic [3:0]              w_curNibble;
    logic                    w_curDp;
    logic                    w_curEn;
    logic                    w_curLead;
    logic [NUM_DIGITS-1:0]   w_anOneHot;
    logic [NUM_DIGITS-1:0]   w_leadZero;
    seg_t                    w_glyph;
    seg_t                    w_litSeg;
    scan_phase_t             w_phase;

    assign w_slotWrap = (r_slotCnt == SLOT_LAST);
    assign w_commit   = w_slotWrap && (r_digitIdx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slotCnt  <= '0;
            r_digitIdx <= '0;
        end else if (w_slotWrap) begin
            r_slotCnt  <= '0;
            r_digitIdx <= w_commit ? '0 : r_digitIdx + 1'b1;
        end else begin
            r_slotCnt  <= r_slotCnt + 1'b1;
        end
    end

    // The active buffer only changes on the edge that restarts the scan at
    // digit 0, so a frame never mixes old and new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadowDigits <= '0;
            r_shadowDp     <= '0;
            r_shadowEn     <= '0;
            r_activeDigits <= '0;
            r_activeDp     <= '0;
            r_activeEn     <= '0;
            r_pending      <= 1'b0;
        end else if (w_commit) begin
            if (load) begin
                r_activeDigits <= digits_in;
                r_activeDp     <= dp_in;
                r_activeEn     <= digit_en_in;
            end else if (r_pending) begin
                r_activeDigits <= r_shadowDigits;
                r_activeDp     <= r_shadowDp;
                r_activeEn     <= r_shadowEn;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_shadowDigits <= digits_in;
            r_shadowDp     <= dp_in;
            r_shadowEn     <= digit_en_in;
            r_pending      <= 1'b1;
        end
    end

    always_comb begin
        w_curNibble = 4'h0;
        w_curDp     = 1'b0;
        w_curEn     = 1'b0;
        w_curLead   = 1'b0;
        w_anOneHot  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digitIdx == IDX_W'(i)) begin
                w_curNibble   = r_activeDigits[4*i +: 4];
                w_curDp       = r_activeDp[i];
                w_curEn       = r_activeEn[i];
                w_curLead     = w_leadZero[i];
                w_anOneHot[i] = 1'b1;
            end
        end
    end

    // Walk down from the top digit; disabled digits neither start nor stop a
    // run of leading zeros. Bit 0 is never marked.
    always_comb begin
        logic higherZero;
        higherZero = 1'b1;
        w_leadZero = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_leadZero[i] = higherZero && (r_activeDigits[4*i +: 4] == 4'h0);
            higherZero    = higherZero &&
                            (!r_activeEn[i] || (r_activeDigits[4*i +: 4] == 4'h0));
        end
    end

    seven_seg_glyph u_glyph (
        .i_nibble   (w_curNibble),
        .i_hexMode  (hex_mode),
        .o_segments (w_glyph)
    );

    assign w_litSeg = (!w_curEn || (lz_suppress && w_curLead)) ? SEG_BLANK : w_glyph;
    assign w_phase  = (r_slotCnt < BLANK_END) ? PHASE_BLANK : PHASE_SHOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg       <= SEG_POL;
            r_dp        <= SEG_ACTIVE_LOW;
            r_an        <= AN_POL;
            r_wrapDly   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_seg       <= w_litSeg ^ SEG_POL;
            r_dp        <= (w_curDp && w_curEn) ^ SEG_ACTIVE_LOW;
            r_an        <= (w_phase == PHASE_BLANK) ? AN_POL : (w_anOneHot ^ AN_POL);
            r_wrapDly   <= w_commit;
            r_frameDone <= r_wrapDly;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign an_out     = r_an;
    assign frame_done = r_frameDone;
    assign pending    = r_pending;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: stimulus pushes one expected frame per load, and the
// monitor checks every output cycle of the frame that starts at frame_done.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G6 = 7'b1111101;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1101111;
    localparam logic [6:0] GA = 7'b1110111;
    localparam logic [6:0] GB = 7'b1111100;
    localparam logic [6:0] GC = 7'b0111001;
    localparam logic [6:0] GD = 7'b1011110;
    localparam logic [6:0] GE = 7'b1111001;
    localparam logic [6:0] GF = 7'b1110001;
    localparam logic [6:0] BL = 7'b0000000;

    typedef struct packed {
        logic [27:0] segs;
        logic [3:0]  dps;
    } frame_t;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic [15:0] digits_in   = '0;
    logic [3:0]  dp_in       = '0;
    logic [3:0]  digit_en_in = '0;
    logic        hex_mode    = 1'b0;
    logic        lz_suppress = 1'b0;
    logic        load        = 1'b0;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;
    logic        pending;

    frame_t expQ[$];
    int     checks   = 0;
    int     failures = 0;
    int     frameNo  = 0;
    logic   monBusy  = 1'b0;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (DIV),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en_in (digit_en_in),
        .hex_mode    (hex_mode),
        .lz_suppress (lz_suppress),
        .load        (load),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .an_out      (an_out),
        .frame_done  (frame_done),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic waitIdle();
        int budget = 0;
        while ((expQ.size() != 0 || monBusy) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("scoreboard_drain", 32'(expQ.size() != 0 || monBusy), 32'd0);
        expQ.delete();
    endtask

    task automatic syncFrame();
        int budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!frame_done && budget < 100);
        checkOutput("frame_sync", 32'(frame_done), 32'd1);
    endtask

    // Loads mid-frame so the data commits at the next wrap, then queues the
    // frame that should appear right after that wrap.
    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dp,
                                 input logic [3:0] en, input logic hex,
                                 input logic lz, input logic [27:0] segs,
                                 input logic [3:0] dps);
        frame_t f;
        waitIdle();
        syncFrame();
        repeat (2) @(negedge clk);
        hex_mode    = hex;
        lz_suppress = lz;
        digits_in   = d;
        dp_in       = dp;
        digit_en_in = en;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
        f.segs = segs;
        f.dps  = dps;
        expQ.push_back(f);
    endtask

    initial begin
        frame_t      f;
        logic [3:0]  oneHot;
        logic [3:0]  expAn;
        logic [6:0]  expSeg;
        logic        expDp;
        int          d;
        int          s;
        forever begin
            @(negedge clk);
            if (rst_n && frame_done && expQ.size() > 0) begin
                f       = expQ.pop_front();
                monBusy = 1'b1;
                for (int k = 0; k < N * DIV; k++) begin
                    if (k > 0) @(negedge clk);
                    d      = k / DIV;
                    s      = k % DIV;
                    oneHot = 4'b0001 << d;
                    expAn  = (s < BLANK) ? 4'hF : ~oneHot;
                    expSeg = ~f.segs[d*7 +: 7];
                    expDp  = ~f.dps[d];
                    checkOutput($sformatf("frame%0d_digit%0d_slot%0d", frameNo, d, s),
                                32'({frame_done, an_out, seg_out, dp_out}),
                                32'({(k == 0), expAn, expSeg, expDp}));
                end
                frameNo++;
                monBusy = 1'b0;
            end
        end
    end

    initial begin
        frame_t f;

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_an",         32'(an_out),     32'hF);
        checkOutput("reset_seg",        32'(seg_out),    32'h7F);
        checkOutput("reset_dp",         32'(dp_out),     32'd1);
        checkOutput("reset_pending",    32'(pending),    32'd0);
        checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h1234, 4'b0100, 4'hF, 1'b0, 1'b0, {G1, G2, G3, G4}, 4'b0100);
        applyStimulus(16'h6789, 4'b1111, 4'hF, 1'b0, 1'b0, {G6, G7, G8, G9}, 4'b1111);
        applyStimulus(16'h000B, 4'b0000, 4'hF, 1'b0, 1'b0, {G0, G0, G0, BL}, 4'b0000);
        applyStimulus(16'h000B, 4'b0000, 4'hF, 1'b1, 1'b0, {G0, G0, G0, GB}, 4'b0000);
        applyStimulus(16'hACEF, 4'b0000, 4'hF, 1'b1, 1'b0, {GA, GC, GE, GF}, 4'b0000);
        applyStimulus(16'h0D00, 4'b0000, 4'hF, 1'b1, 1'b0, {G0, GD, G0, G0}, 4'b0000);
        applyStimulus(16'h0050, 4'b0000, 4'hF, 1'b0, 1'b1, {BL, BL, G5, G0}, 4'b0000);
        applyStimulus(16'h0000, 4'b0000, 4'hF, 1'b0, 1'b1, {BL, BL, BL, G0}, 4'b0000);
        applyStimulus(16'h3005, 4'b1001, 4'b0111, 1'b0, 1'b1, {BL, BL, BL, G5}, 4'b0001);

        // Two loads in one frame: the later one must be the one displayed.
        waitIdle();
        syncFrame();
        repeat (2) @(negedge clk);
        lz_suppress = 1'b0;
        digits_in   = 16'h1111;
        dp_in       = 4'b0000;
        digit_en_in = 4'hF;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
        checkOutput("pending_after_first_load", 32'(pending), 32'd1);
        digits_in   = 16'h2222;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
        checkOutput("pending_after_second_load", 32'(pending), 32'd1);
        f.segs = {G2, G2, G2, G2};
        f.dps  = 4'b0000;
        expQ.push_back(f);
        waitIdle();
        checkOutput("pending_after_commit", 32'(pending), 32'd0);

        // Load exactly in the commit cycle: two cycles before frame_done.
        waitIdle();
        syncFrame();
        repeat (14) @(negedge clk);
        digits_in = 16'h9999;
        load      = 1'b1;
        f.segs = {G9, G9, G9, G9};
        f.dps  = 4'b0000;
        expQ.push_back(f);
        @(negedge clk);
        load = 1'b0;
        checkOutput("bypass_pending_cycle1", 32'(pending), 32'd0);
        @(negedge clk);
        checkOutput("bypass_pending_cycle2", 32'(pending), 32'd0);
        waitIdle();

        // Reset mid-scan with uncommitted data pending.
        syncFrame();
        repeat (2) @(negedge clk);
        digits_in = 16'h5555;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        checkOutput("pending_before_reset", 32'(pending), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midscan_reset_an",      32'(an_out),     32'hF);
        checkOutput("midscan_reset_seg",     32'(seg_out),    32'h7F);
        checkOutput("midscan_reset_dp",      32'(dp_out),     32'd1);
        checkOutput("midscan_reset_pending", 32'(pending),    32'd0);
        checkOutput("midscan_reset_fdone",   32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        f.segs = {BL, BL, BL, BL};
        f.dps  = 4'b0000;
        expQ.push_back(f);
        waitIdle();
        checkOutput("pending_after_reset_frame", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
